// File: rtl/vdp_pkg.sv
// ----------------------------------------------------------------------------
// vdp_pkg
// Shared definitions for the VDP raster timing block:
//   - default 640x480@60 timing values (used as parameter defaults)
//   - default coordinate width
//   - line-fetch request FSM state encoding
// Optional build macro used by the top: VDP_FRAME_COUNT_EN
// ----------------------------------------------------------------------------
package vdp_pkg;

    localparam int CORDW_DEF  = 11;

    localparam int H_RES_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;

    localparam int V_RES_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } req_state_t;

endpackage

// File: rtl/vdp_line_req.sv
// ----------------------------------------------------------------------------
// vdp_line_req
// Per-line fetch request FSM for the draw side.
//   i_clk_pix      pixel clock
//   i_rst_pix      synchronous active-high reset
//   i_sx_nxt       raster x the counters will show next cycle
//   i_sy_nxt       raster y the counters will show next cycle
//   i_line_ack     draw side accepts the pending request
//   i_underrun_clr clears the sticky underrun flag
//   o_line_req     request pending
//   o_line_y       line being requested
//   o_underrun     sticky: a request was not acked before its line began
// Working from the next-cycle coordinates keeps line_req/line_y/underrun
// aligned with the registered sx/sy seen by consumers.
// ----------------------------------------------------------------------------
module vdp_line_req
    import vdp_pkg::*;
#(
    parameter int CORDW   = CORDW_DEF,
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int V_TOTAL = V_RES_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF
) (
    input  logic             i_clk_pix,
    input  logic             i_rst_pix,
    input  logic [CORDW-1:0] i_sx_nxt,
    input  logic [CORDW-1:0] i_sy_nxt,
    input  logic             i_line_ack,
    input  logic             i_underrun_clr,
    output logic             o_line_req,
    output logic [CORDW-1:0] o_line_y,
    output logic             o_underrun
);

    req_state_t       r_state;
    logic [CORDW-1:0] r_line_y;
    logic             r_underrun;

    logic [CORDW-1:0] w_next_line;
    logic             w_issue;
    logic             w_deadline;
    logic             w_miss;

    // Line that follows the one being scanned; the last line wraps to 0 so
    // line 0 gets fetched during the final blanking line of the frame.
    assign w_next_line = (i_sy_nxt == CORDW'(V_TOTAL - 1)) ? '0 : i_sy_nxt + CORDW'(1);
    assign w_issue     = (i_sx_nxt == CORDW'(H_RES)) && (w_next_line < CORDW'(V_RES));
    // This edge wraps sx to 0: the requested line starts now.
    assign w_deadline  = (i_sx_nxt == '0);
    // An ack on the deadline cycle still counts as in time.
    assign w_miss      = (r_state == ST_REQ) && !i_line_ack && w_deadline;

    always_ff @(posedge i_clk_pix) begin
        if (i_rst_pix) begin
            r_state    <= ST_IDLE;
            r_line_y   <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (w_issue) begin
                    r_state  <= ST_REQ;
                    r_line_y <= w_next_line;
                end
            end else if (i_line_ack || w_deadline) begin
                r_state <= ST_IDLE;
            end

            // A new miss takes priority over a clear in the same cycle.
            if (w_miss) begin
                r_underrun <= 1'b1;
            end else if (i_underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign o_line_req = (r_state == ST_REQ);
    assign o_line_y   = r_line_y;
    assign o_underrun = r_underrun;

endmodule

// File: rtl/vdp_display_timing.sv
// ----------------------------------------------------------------------------
// vdp_display_timing
// Pixel-clock raster generator at the head of the VDP pixel pipeline.
//   clk_pix, rst_pix     pixel clock, synchronous active-high reset
//   sx, sy               raster position
//   de                   active video
//   hsync, vsync         syncs, active level H_POL / V_POL
//   frame, line          1-cycle strobes at (0,0) and at every sx=0
//   line_req, line_y     fetch request to the draw side, one hblank ahead
//   line_ack             draw side accepts the request
//   underrun             sticky missed-deadline flag, underrun_clr clears it
//   frame_count          frames since reset
// Build macro VDP_FRAME_COUNT_EN: when defined frame_count counts frame
// strobes (mod 2^16); otherwise it is tied to 0 and no counter exists.
// ----------------------------------------------------------------------------
module vdp_display_timing
    import vdp_pkg::*;
#(
    parameter int   CORDW  = CORDW_DEF,
    parameter int   H_RES  = H_RES_DEF,
    parameter int   H_FP   = H_FP_DEF,
    parameter int   H_SYNC = H_SYNC_DEF,
    parameter int   H_BP   = H_BP_DEF,
    parameter int   V_RES  = V_RES_DEF,
    parameter int   V_FP   = V_FP_DEF,
    parameter int   V_SYNC = V_SYNC_DEF,
    parameter int   V_BP   = V_BP_DEF,
    parameter logic H_POL  = 1'b0,
    parameter logic V_POL  = 1'b0
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic             frame,
    output logic             line,
    output logic             line_req,
    output logic [CORDW-1:0] line_y,
    input  logic             line_ack,
    output logic             underrun,
    input  logic             underrun_clr,
    output logic [15:0]      frame_count
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] SX_MAX = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] SY_MAX = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC - 1);

    logic [CORDW-1:0] r_sx, r_sy;
    logic             r_de, r_hsync, r_vsync, r_frame, r_line;
    logic [CORDW-1:0] w_sx_nxt, w_sy_nxt;

    always_comb begin
        w_sx_nxt = r_sx + CORDW'(1);
        w_sy_nxt = r_sy;
        if (r_sx == SX_MAX) begin
            w_sx_nxt = '0;
            w_sy_nxt = (r_sy == SY_MAX) ? '0 : r_sy + CORDW'(1);
        end
    end

    // All raster outputs are decoded from the next position so they land in
    // the same cycle as the sx/sy they describe. The reset position is the
    // last pixel of the frame, so release steps straight onto (0,0).
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_sx    <= SX_MAX;
            r_sy    <= SY_MAX;
            r_de    <= 1'b0;
            r_hsync <= ~H_POL;
            r_vsync <= ~V_POL;
            r_frame <= 1'b0;
            r_line  <= 1'b0;
        end else begin
            r_sx    <= w_sx_nxt;
            r_sy    <= w_sy_nxt;
            r_de    <= (w_sx_nxt < CORDW'(H_RES)) && (w_sy_nxt < CORDW'(V_RES));
            r_hsync <= ((w_sx_nxt >= HS_BEG) && (w_sx_nxt <= HS_END)) ? H_POL : ~H_POL;
            r_vsync <= ((w_sy_nxt >= VS_BEG) && (w_sy_nxt <= VS_END)) ? V_POL : ~V_POL;
            r_frame <= (w_sx_nxt == '0) && (w_sy_nxt == '0);
            r_line  <= (w_sx_nxt == '0);
        end
    end

    vdp_line_req #(
        .CORDW   (CORDW),
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .V_TOTAL (V_TOTAL)
    ) u_line_req (
        .i_clk_pix      (clk_pix),
        .i_rst_pix      (rst_pix),
        .i_sx_nxt       (w_sx_nxt),
        .i_sy_nxt       (w_sy_nxt),
        .i_line_ack     (line_ack),
        .i_underrun_clr (underrun_clr),
        .o_line_req     (line_req),
        .o_line_y       (line_y),
        .o_underrun     (underrun)
    );

`ifdef VDP_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    // Counts on the strobe cycle itself; the new value shows one cycle later.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_frame_count <= '0;
        end else if (r_frame) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`else
    assign frame_count = 16'd0;
`endif

    assign sx    = r_sx;
    assign sy    = r_sy;
    assign de    = r_de;
    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign frame = r_frame;
    assign line  = r_line;

endmodule

// File: tb/tb_vdp_display_timing.sv
// ----------------------------------------------------------------------------
// tb_vdp_display_timing
// Bench for vdp_display_timing. A small-raster instance is checked every cycle
// against a position-based reference model; a default-timing instance is
// checked at fixed cycles of its first line from a constant table.
// ----------------------------------------------------------------------------
module tb_vdp_display_timing;

    localparam int HR = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VR = 6,  VFP = 2, VSY = 2, VBP = 2;
    localparam int HT = HR + HFP + HSY + HBP;   // 24
    localparam int VT = VR + VFP + VSY + VBP;   // 12
    localparam int FRAME = HT * VT;             // 288
    localparam bit HPOL = 1'b0, VPOL = 1'b0;

    logic clk_pix = 1'b0;
    logic rst_pix = 1'b1;
    logic line_ack = 1'b0, underrun_clr = 1'b0;
    logic [10:0] sx, sy, line_y;
    logic de, hsync, vsync, frame, line, line_req, underrun;
    logic [15:0] frame_count;

    logic d_ack = 1'b0, d_clr = 1'b0;
    logic [10:0] d_sx, d_sy, d_line_y;
    logic d_de, d_hs, d_vs, d_fr, d_ln, d_req, d_ur;
    logic [15:0] d_fc;

    always #5 clk_pix = ~clk_pix;

    vdp_display_timing #(
        .CORDW(11), .H_RES(HR), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_RES(VR), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .H_POL(HPOL), .V_POL(VPOL)
    ) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy), .de(de),
        .hsync(hsync), .vsync(vsync), .frame(frame), .line(line),
        .line_req(line_req), .line_y(line_y), .line_ack(line_ack),
        .underrun(underrun), .underrun_clr(underrun_clr), .frame_count(frame_count)
    );

    vdp_display_timing dut_def (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(d_sx), .sy(d_sy), .de(d_de),
        .hsync(d_hs), .vsync(d_vs), .frame(d_fr), .line(d_ln),
        .line_req(d_req), .line_y(d_line_y), .line_ack(d_ack),
        .underrun(d_ur), .underrun_clr(d_clr), .frame_count(d_fc)
    );

    logic [63:0] dut_vec;
    assign dut_vec = {8'd0, sx, sy, de, hsync, vsync, frame, line,
                      line_req, line_y, underrun, frame_count};

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    // Reference model: linear raster position plus request bookkeeping.
    bit m_rst = 1'b1;
    int m_p   = FRAME - 1;
    bit m_req = 1'b0;
    int m_y   = 0;
    bit m_ur  = 1'b0;
    int m_fc  = 0;

    task automatic summary_and_finish();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_vec();
        int x, y;
        logic e_de, e_hs, e_vs, e_fr, e_ln;
        if (m_rst) begin
            x = HT - 1; y = VT - 1;
            e_de = 1'b0; e_hs = ~HPOL; e_vs = ~VPOL; e_fr = 1'b0; e_ln = 1'b0;
        end else begin
            x = m_p % HT; y = m_p / HT;
            e_de = (x < HR) && (y < VR);
            e_hs = (x >= HR + HFP && x < HR + HFP + HSY) ? HPOL : ~HPOL;
            e_vs = (y >= VR + VFP && y < VR + VFP + VSY) ? VPOL : ~VPOL;
            e_fr = (m_p == 0);
            e_ln = (x == 0);
        end
        return {8'd0, 11'(x), 11'(y), e_de, e_hs, e_vs, e_fr, e_ln,
                m_req, 11'(m_y), m_ur, 16'(m_fc)};
    endfunction

    task automatic model_adv(input bit r, input bit a, input bit c);
        int x, np, nx, ny, n;
        bit miss;
        if (r) begin
            m_rst = 1'b1; m_p = FRAME - 1; m_req = 1'b0; m_y = 0; m_ur = 1'b0; m_fc = 0;
            return;
        end
        x    = m_p % HT;
        np   = (m_p + 1) % FRAME;
        nx   = np % HT;
        ny   = np / HT;
        miss = m_req && !a && (x == HT - 1);
`ifdef VDP_FRAME_COUNT_EN
        if (!m_rst && m_p == 0) m_fc = (m_fc + 1) % 65536;
`endif
        if (m_req) begin
            if (a || x == HT - 1) m_req = 1'b0;
        end else if (nx == HR) begin
            n = (ny + 1) % VT;
            if (n < VR) begin
                m_req = 1'b1;
                m_y   = n;
            end
        end
        if (miss) m_ur = 1'b1;
        else if (c) m_ur = 1'b0;
        m_rst = 1'b0;
        m_p   = np;
    endtask

    task automatic step(input bit r, input bit a, input bit c);
        rst_pix = r; line_ack = a; underrun_clr = c;
        model_adv(r, a, c);
        @(posedge clk_pix);
        #1;
        ncyc++;
        chk($sformatf("cyc%0d", ncyc), dut_vec, exp_vec());
        if (bad >= 50) summary_and_finish();
    endtask

    task automatic wait_req(input string name);
        int k;
        k = 0;
        while (line_req && k < HT) begin step(0, 0, 0); k++; end
        k = 0;
        while (!line_req && k < 2 * FRAME) begin step(0, 0, 0); k++; end
        chk({name, "_rise"}, 64'(line_req), 64'(1));
        chk({name, "_rise_sx"}, 64'(sx), 64'(HR));
        chk({name, "_line_y"}, 64'(line_y), 64'((int'(sy) + 1) % VT));
    endtask

    task automatic run_to_last_pixel();
        int k;
        k = 0;
        while (sx != 11'(HT - 1) && k < HT) begin step(0, 0, 0); k++; end
    endtask

    typedef struct {
        int          cyc;
        logic [10:0] sx, sy;
        logic        de, hs, vs, fr, ln;
    } dvec_t;

    dvec_t dv [9];

    initial begin
        int ti, cnt, dec, vsl, viol;

        // Default 640x480 timing: expected values at cycles after reset release.
        dv[0] = '{0,   11'd799, 11'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        dv[1] = '{1,   11'd0,   11'd0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        dv[2] = '{2,   11'd1,   11'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        dv[3] = '{640, 11'd639, 11'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        dv[4] = '{641, 11'd640, 11'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        dv[5] = '{657, 11'd656, 11'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        dv[6] = '{752, 11'd751, 11'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        dv[7] = '{753, 11'd752, 11'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        dv[8] = '{801, 11'd0,   11'd1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        ti = 0;
        for (int k = 0; k <= 801; k++) begin
            if (k > 0) step(0, bit'($urandom_range(0, 1)), 1'b0);
            if (ti < 9 && dv[ti].cyc == k) begin
                chk($sformatf("def_cyc%0d", k),
                    64'({d_sx, d_sy, d_de, d_hs, d_vs, d_fr, d_ln}),
                    64'({dv[ti].sx, dv[ti].sy, dv[ti].de, dv[ti].hs,
                         dv[ti].vs, dv[ti].fr, dv[ti].ln}));
                ti++;
            end
        end

        // Whole-frame measurements on the small raster.
        cnt = 0;
        while (!frame && cnt < 2 * FRAME) begin step(0, bit'($urandom_range(0, 1)), 0); cnt++; end
        chk("frame_found", 64'(frame), 64'(1));
        cnt = 0; dec = 0; vsl = 0; viol = 0;
        while (1) begin
            if (de) dec++;
            if (!vsync) begin
                vsl++;
                if (sy < 11'(VR + VFP) || sy >= 11'(VR + VFP + VSY)) viol++;
            end
            step(0, bit'($urandom_range(0, 1)), 0);
            cnt++;
            if (frame || cnt >= 2 * FRAME) break;
        end
        chk("frame_period", 64'(cnt), 64'(FRAME));
        chk("de_per_frame", 64'(dec), 64'(HR * VR));
        chk("vsync_cycles", 64'(vsl), 64'(VSY * HT));
        chk("vsync_rows", 64'(viol), 64'(0));

        // Directed request sequences from a clean reset.
        step(1, 0, 0); step(1, 0, 0);

        wait_req("lat5");
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        chk("lat5_hold", 64'(line_req), 64'(1));
        step(0, 1, 0);
        chk("lat5_fall", 64'(line_req), 64'(0));
        chk("lat5_ur", 64'(underrun), 64'(0));

        wait_req("noack");
        run_to_last_pixel();
        step(0, 0, 0);
        chk("noack_sx", 64'(sx), 64'(0));
        chk("noack_drop", 64'(line_req), 64'(0));
        chk("noack_ur", 64'(underrun), 64'(1));
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        chk("ur_sticky", 64'(underrun), 64'(1));
        step(0, 0, 1);
        chk("ur_clr", 64'(underrun), 64'(0));

        wait_req("ackdl");
        run_to_last_pixel();
        step(0, 1, 0);
        chk("ackdl_req", 64'(line_req), 64'(0));
        chk("ackdl_ur", 64'(underrun), 64'(0));

        wait_req("miss1");
        run_to_last_pixel();
        step(0, 0, 0);
        chk("miss1_ur", 64'(underrun), 64'(1));
        wait_req("miss2");
        run_to_last_pixel();
        step(0, 0, 1);
        chk("clr_vs_miss", 64'(underrun), 64'(1));
        step(0, 0, 1);
        chk("clr_after", 64'(underrun), 64'(0));

        wait_req("midrst");
        step(0, 0, 0); step(0, 0, 0);
        step(1, 0, 0);
        chk("midrst_req", 64'(line_req), 64'(0));
        chk("midrst_pos", 64'({sx, sy}), 64'({11'(HT - 1), 11'(VT - 1)}));
        step(1, 0, 0);
        step(0, 0, 0);
        chk("midrst_rel", 64'({sx, sy, de, frame, line, underrun}),
            64'({11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0}));

        // Frame counter across three frames from reset.
        step(1, 0, 0);
        for (int i = 0; i < 3 * FRAME; i++) step(0, 1, 0);
`ifdef VDP_FRAME_COUNT_EN
        chk("fc3", 64'(frame_count), 64'(3));
`else
        chk("fc3", 64'(frame_count), 64'(0));
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(bit'($urandom_range(0, 999) == 0),
                 bit'($urandom_range(0, 3) == 0),
                 bit'($urandom_range(0, 15) == 0));
        end

        summary_and_finish();
    end

endmodule
